cam_sensor_emu: RTL and testbench

- Synthetic camera source that drives VSYNC/HREF/DATA with OV-style frame timing.
- Lets pixel_buffer, the SRAM write path and dump_sequencer be exercised on the board without a sensor; also serves as a bench model.
- A 2:1 mux at the camera input selects sensor or emulator; the emulator runs in the pixel_clk domain.
- Generates deterministic byte patterns so frames dumped over RS232 can be checked exactly.

---
 rtl/cam_sensor_emu_if.sv | 9 +
 rtl/cam_sensor_emu.sv | 118 +++++++++++
 tb/tb_cam_sensor_emu.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_sensor_emu_if.sv
// rtl/cam_sensor_emu_if.sv - OV-style camera bus (VSYNC/HREF/DATA) shared by emulator and consumers
interface cam_sensor_emu_if;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] DATA;

  modport master (output VSYNC, HREF, DATA);
  modport slave  (input  VSYNC, HREF, DATA);
endinterface

// File: rtl/cam_sensor_emu.sv
// rtl/cam_sensor_emu.sv - synthetic camera source producing OV-style frame timing and deterministic pixel patterns
module cam_sensor_emu #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  cam_sensor_emu_if.master       cam,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt
);

  localparam int          LINE_LEN  = H_ACTIVE + H_BLANK;
  localparam logic [11:0] H_LAST    = 12'(LINE_LEN - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [10:0] VS_LAST   = 11'(VSYNC_LINES - 1);
  localparam logic [10:0] VB_LAST   = 11'(V_BACK - 1);
  localparam logic [10:0] VA_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VF_LAST   = 11'(V_FRONT - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state, state_n;
  logic [11:0] h_cnt, h_n;
  logic [10:0] line_cnt, line_n;
  logic [1:0]  pat_q;
  logic        latch_pat;
  logic        line_end;
  logic        vsync_d, href_d, busy_d, done_d;
  logic [7:0]  data_d;

  assign line_end = (h_cnt == H_LAST);

  // Outputs are decoded from the current position and registered, so they trail the counters by one edge.
  always_comb begin
    state_n   = state;
    h_n       = line_end ? 12'd0 : h_cnt + 12'd1;
    line_n    = line_end ? line_cnt + 11'd1 : line_cnt;
    latch_pat = 1'b0;
    done_d    = 1'b0;
    case (state)
      S_IDLE: begin
        h_n    = 12'd0;
        line_n = 11'd0;
        if (enable) begin
          state_n   = S_VSYNC;
          latch_pat = 1'b1;
        end
      end
      S_VSYNC: if (line_end && line_cnt == VS_LAST) begin
        state_n = S_VBACK;
        line_n  = 11'd0;
      end
      S_VBACK: if (line_end && line_cnt == VB_LAST) begin
        state_n = S_ACTIVE;
        line_n  = 11'd0;
      end
      S_ACTIVE: if (line_end && line_cnt == VA_LAST) begin
        state_n = S_VFRONT;
        line_n  = 11'd0;
      end
      S_VFRONT: if (line_end && line_cnt == VF_LAST) begin
        done_d    = 1'b1;
        line_n    = 11'd0;
        state_n   = enable ? S_VSYNC : S_IDLE;
        latch_pat = enable;
      end
      default: state_n = S_IDLE;
    endcase

    vsync_d = (state == S_VSYNC);
    busy_d  = (state != S_IDLE);
    href_d  = (state == S_ACTIVE) && (h_cnt < H_ACT);
    data_d  = 8'h00;
    if (href_d) begin
      case (pat_q)
        2'd0:    data_d = h_cnt[7:0];
        2'd1:    data_d = line_cnt[7:0];
        2'd2:    data_d = h_cnt[7:0] ^ frame_cnt[7:0];
        default: data_d = h_cnt[0] ? 8'hAA : 8'h55;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      line_cnt   <= '0;
      pat_q      <= '0;
      cam.VSYNC  <= 1'b0;
      cam.HREF   <= 1'b0;
      cam.DATA   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      h_cnt      <= h_n;
      line_cnt   <= line_n;
      if (latch_pat) pat_q <= pattern_sel;
      cam.VSYNC  <= vsync_d;
      cam.HREF   <= href_d;
      cam.DATA   <= data_d;
      busy       <= busy_d;
      frame_done <= done_d;
      frame_cnt  <= frame_cnt + {15'd0, done_d};
    end
  end

endmodule

// File: tb/tb_cam_sensor_emu.sv
// tb/tb_cam_sensor_emu.sv - self-checking bench for cam_sensor_emu
module tb_cam_sensor_emu;
  localparam int HA = 8, HB = 4, VS = 1, VB = 1, VA = 3, VF = 1;
  localparam int LL = HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LL;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  cam_sensor_emu_if cam ();

  cam_sensor_emu #(
    .H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .cam(cam), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference: frame position pos (-1 idle, 0 start latched, 1..FRAME visible cycle of the frame).
  int          pos = -1;
  bit          cont = 0;
  logic [1:0]  mpat = 0;
  logic [15:0] mfcnt = 0;

  task automatic model_reset();
    pos = -1; cont = 0; mpat = 0; mfcnt = 0;
  endtask

  task automatic model_edge(input bit en, input logic [1:0] sel);
    if (pos < 0) begin
      if (en) begin pos = 0; mpat = sel; end
    end else if (pos < FRAME) begin
      pos++;
      if (pos == FRAME) begin
        mfcnt++;
        cont = en;
        if (en) mpat = sel;
      end
    end else begin
      pos = cont ? 1 : -1;
    end
  endtask

  task automatic compare_all();
    logic evs, ehr, ebz, efd;
    logic [7:0] ed;
    int l, h, al;
    evs = 0; ehr = 0; ebz = 0; efd = 0; ed = 8'h00;
    if (pos >= 1) begin
      l = (pos - 1) / LL;
      h = (pos - 1) % LL;
      al = l - VS - VB;
      evs = (l < VS);
      ebz = 1;
      efd = (pos == FRAME);
      if (al >= 0 && al < VA && h < HA) begin
        ehr = 1;
        case (mpat)
          2'd0: ed = h[7:0];
          2'd1: ed = al[7:0];
          2'd2: ed = h[7:0] ^ mfcnt[7:0];
          default: ed = (h % 2 == 1) ? 8'hAA : 8'h55;
        endcase
      end
    end
    check("vsync", cam.VSYNC, evs);
    check("href", cam.HREF, ehr);
    check("data", cam.DATA, ed);
    check("busy", busy, ebz);
    check("frame_done", frame_done, efd);
    check("frame_cnt", frame_cnt, mfcnt);
  endtask

  task automatic run_cycle(input bit en, input logic [1:0] sel);
    enable = en;
    pattern_sel = sel;
    @(posedge clk);
    model_edge(en, sel);
    #1;
    compare_all();
  endtask

  typedef struct {
    int          edge_no;
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        bz;
    logic        fd;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[18];
  logic [7:0] pat2_exp[8];
  logic [7:0] cap[$];

  initial begin
    int e;
    bit ren;
    vecs = '{
      '{0, 0, 0, 8'h00, 0, 0, 16'd0}, '{1, 1, 0, 8'h00, 1, 0, 16'd0},
      '{12, 1, 0, 8'h00, 1, 0, 16'd0}, '{13, 0, 0, 8'h00, 1, 0, 16'd0},
      '{24, 0, 0, 8'h00, 1, 0, 16'd0}, '{25, 0, 1, 8'h00, 1, 0, 16'd0},
      '{29, 0, 1, 8'h04, 1, 0, 16'd0}, '{32, 0, 1, 8'h07, 1, 0, 16'd0},
      '{33, 0, 0, 8'h00, 1, 0, 16'd0}, '{37, 0, 1, 8'h00, 1, 0, 16'd0},
      '{44, 0, 1, 8'h07, 1, 0, 16'd0}, '{49, 0, 1, 8'h00, 1, 0, 16'd0},
      '{56, 0, 1, 8'h07, 1, 0, 16'd0}, '{57, 0, 0, 8'h00, 1, 0, 16'd0},
      '{71, 0, 0, 8'h00, 1, 0, 16'd0}, '{72, 0, 0, 8'h00, 1, 1, 16'd1},
      '{73, 0, 0, 8'h00, 0, 0, 16'd1}, '{80, 0, 0, 8'h00, 0, 0, 16'd1}
    };
    pat2_exp = '{8'h01, 8'h00, 8'h03, 8'h02, 8'h05, 8'h04, 8'h07, 8'h06};

    reset_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vsync", cam.VSYNC, 0);
    check("rst_href", cam.HREF, 0);
    check("rst_data", cam.DATA, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);
    reset_n = 1'b1;

    // Single-cycle enable pulse at edge 0, pattern 0: fixed timing table.
    @(posedge clk);
    #1;
    enable = 1'b1;
    e = -1;
    foreach (vecs[i]) begin
      while (e < vecs[i].edge_no) begin
        @(posedge clk);
        e++;
        #1;
        if (e == 0) enable = 1'b0;
      end
      check($sformatf("tbl_vsync@%0d", e), cam.VSYNC, vecs[i].vs);
      check($sformatf("tbl_href@%0d", e), cam.HREF, vecs[i].hr);
      check($sformatf("tbl_data@%0d", e), cam.DATA, vecs[i].d);
      check($sformatf("tbl_busy@%0d", e), busy, vecs[i].bz);
      check($sformatf("tbl_done@%0d", e), frame_done, vecs[i].fd);
      check($sformatf("tbl_fcnt@%0d", e), frame_cnt, vecs[i].fc);
    end

    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();

    // Three back-to-back frames, patterns 1/2/3 sampled at each frame start, noise on inputs mid-frame.
    for (int c = 0; c <= 3 * FRAME + 4; c++) begin
      bit en;
      logic [1:0] sel;
      if (c == 0 || c == FRAME || c == 2 * FRAME) begin
        en = 1;
        sel = 2'(c / FRAME + 1);
      end else begin
        en = (c < 3 * FRAME) ? 1'($urandom_range(0, 1)) : 1'b0;
        sel = 2'($urandom_range(0, 3));
      end
      run_cycle(en, sel);
      if (c > FRAME && c <= 2 * FRAME && cam.HREF && cap.size() < 8) cap.push_back(cam.DATA);
    end
    check("pat2_count", cap.size(), 8);
    foreach (pat2_exp[i]) check($sformatf("pat2_byte%0d", i), (i < cap.size()) ? cap[i] : 8'hxx, pat2_exp[i]);
    check("three_frames", frame_cnt, 3);

    // Asynchronous reset in the middle of the second active line.
    run_cycle(1, 2'd0);
    while (pos != 40 && pos >= 0) run_cycle(0, 2'($urandom_range(0, 3)));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_vsync", cam.VSYNC, 0);
    check("arst_href", cam.HREF, 0);
    check("arst_data", cam.DATA, 0);
    check("arst_busy", busy, 0);
    check("arst_fcnt", frame_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("arst_nodone", frame_done, 0);
    end
    reset_n = 1'b1;
    model_reset();
    run_cycle(1, 2'd3);
    for (int k = 0; k < FRAME + 3; k++) run_cycle(0, 2'($urandom_range(0, 3)));

    // Random enable/pattern activity against the reference.
    ren = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) ren = ~ren;
      run_cycle(ren, 2'($urandom_range(0, 3)));
    end

    // Counter wrap: preload 0xFFFF while idle, then one frame.
    for (int k = 0; k < FRAME + 3; k++) run_cycle(0, 2'd0);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    #1;
    mfcnt = 16'hFFFF;
    check("wrap_preload", frame_cnt, 16'hFFFF);
    run_cycle(1, 2'd2);
    for (int k = 0; k < FRAME + 2; k++) run_cycle(0, 2'd0);
    check("wrap_zero", frame_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
